// File: rtl/lb_arbiter.sv
// lb_arbiter: two-master round-robin arbiter for the local register bus.
//
// Masters A and B post requests (held until granted). One request is
// accepted per cycle and issued as a registered bus cycle on the next
// cycle. When both masters request, the current owner keeps the bus until
// it has taken burst_max consecutive grants, then the other master wins.
// Read data returns read_lat cycles after the strobe. A tag pipe of the
// same depth remembers which master issued each read. The data is
// registered into that master's rdata port with a one-cycle rvalid pulse.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   x_req/x_rd/x_addr/x_wdata  master request (x = a, b)
//   x_gnt                      combinational grant (accept this cycle)
//   x_rvalid/x_rdata           read return to master x
//   lb_addr/lb_strobe/lb_rd/lb_wdata  registered bus cycle
//   lb_rdata                   bus read data, valid read_lat after strobe
//
// Optional build macro LB_ARB_STATS_EN adds stats_clr and the saturating
// 16-bit counters a_grants, b_grants and conflicts.
module lb_arbiter #(
  parameter int aw        = 24,
  parameter int dw        = 32,
  parameter int read_lat  = 3,
  parameter int burst_max = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_rd,
  input  logic [aw-1:0] a_addr,
  input  logic [dw-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [dw-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_rd,
  input  logic [aw-1:0] b_addr,
  input  logic [dw-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [dw-1:0] b_rdata,
`ifdef LB_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   a_grants,
  output logic [15:0]   b_grants,
  output logic [15:0]   conflicts,
`endif
  output logic [aw-1:0] lb_addr,
  output logic          lb_strobe,
  output logic          lb_rd,
  output logic [dw-1:0] lb_wdata,
  input  logic [dw-1:0] lb_rdata
);

  localparam int               CNT_W       = $clog2(burst_max + 1);
  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(burst_max);

  // Master identity encoding used by owner and tags: 0 = A, 1 = B.
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                accept;

  logic                lb_strobe_q, lb_strobe_d;
  logic                lb_rd_q, lb_rd_d;
  logic                lb_id_q, lb_id_d;
  logic [aw-1:0]       lb_addr_q, lb_addr_d;
  logic [dw-1:0]       lb_wdata_q, lb_wdata_d;

  logic [read_lat-1:0] tag_vld_q, tag_vld_d;
  logic [read_lat-1:0] tag_id_q, tag_id_d;

  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [dw-1:0]       a_rdata_q, a_rdata_d;
  logic [dw-1:0]       b_rdata_q, b_rdata_d;

  // Grants are masked while reset is asserted so every output reads 0.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        // Owner keeps the bus until its burst allowance is used up.
        if (burst_cnt_q < BURST_MAX_C) begin
          a_gnt = ~owner_q;
          b_gnt = owner_q;
        end else begin
          a_gnt = owner_q;
          b_gnt = ~owner_q;
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_comb begin
    accept      = a_gnt | b_gnt;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (accept) begin
      if (b_gnt == owner_q) begin
        burst_cnt_d = (burst_cnt_q < BURST_MAX_C) ? burst_cnt_q + CNT_W'(1)
                                                  : burst_cnt_q;
      end else begin
        owner_d     = b_gnt;
        burst_cnt_d = CNT_W'(1);
      end
    end

    // Bus fields hold their last values between transactions.
    lb_strobe_d = accept;
    lb_id_d     = b_gnt;
    lb_rd_d     = lb_rd_q;
    lb_addr_d   = lb_addr_q;
    lb_wdata_d  = lb_wdata_q;
    if (a_gnt) begin
      lb_rd_d    = a_rd;
      lb_addr_d  = a_addr;
      lb_wdata_d = a_wdata;
    end else if (b_gnt) begin
      lb_rd_d    = b_rd;
      lb_addr_d  = b_addr;
      lb_wdata_d = b_wdata;
    end

    // Tag pipe advances every cycle; its last stage lines up with the
    // cycle in which lb_rdata carries the tagged read's data.
    tag_vld_d = (tag_vld_q << 1) | read_lat'(lb_strobe_q & lb_rd_q);
    tag_id_d  = (tag_id_q << 1) | read_lat'(lb_id_q);

    a_rvalid_d = tag_vld_q[read_lat-1] & ~tag_id_q[read_lat-1];
    b_rvalid_d = tag_vld_q[read_lat-1] & tag_id_q[read_lat-1];
    a_rdata_d  = a_rvalid_d ? lb_rdata : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? lb_rdata : b_rdata_q;
  end

  // Reset owner=B with a full burst count so the first tie goes to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= 1'b1;
      burst_cnt_q <= BURST_MAX_C;
      lb_strobe_q <= 1'b0;
      lb_rd_q     <= 1'b0;
      lb_id_q     <= 1'b0;
      lb_addr_q   <= '0;
      lb_wdata_q  <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      lb_strobe_q <= lb_strobe_d;
      lb_rd_q     <= lb_rd_d;
      lb_id_q     <= lb_id_d;
      lb_addr_q   <= lb_addr_d;
      lb_wdata_q  <= lb_wdata_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign lb_strobe = lb_strobe_q;
  assign lb_rd     = lb_rd_q;
  assign lb_addr   = lb_addr_q;
  assign lb_wdata  = lb_wdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

`ifdef LB_ARB_STATS_EN
  logic [15:0] a_grants_q, a_grants_d;
  logic [15:0] b_grants_q, b_grants_d;
  logic [15:0] conflicts_q, conflicts_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    a_grants_d  = sat_inc(a_grants_q, a_gnt);
    b_grants_d  = sat_inc(b_grants_q, b_gnt);
    conflicts_d = sat_inc(conflicts_q, a_req & b_req);
    if (stats_clr) begin
      a_grants_d  = '0;
      b_grants_d  = '0;
      conflicts_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_grants_q  <= '0;
      b_grants_q  <= '0;
      conflicts_q <= '0;
    end else begin
      a_grants_q  <= a_grants_d;
      b_grants_q  <= b_grants_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign a_grants  = a_grants_q;
  assign b_grants  = b_grants_q;
  assign conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_lb_arbiter.sv
module tb_lb_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RL = 3;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_rd = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_rd = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic [DW-1:0] lb_rdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata, lb_wdata;
  logic [AW-1:0] lb_addr;
  logic          lb_strobe, lb_rd;
`ifdef LB_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   a_grants, b_grants, conflicts;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  lb_arbiter #(.aw(AW), .dw(DW), .read_lat(RL), .burst_max(BM)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_rd(a_rd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_rd(b_rd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef LB_ARB_STATS_EN
    .stats_clr(stats_clr), .a_grants(a_grants), .b_grants(b_grants),
    .conflicts(conflicts),
`endif
    .lb_addr(lb_addr), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
    .lb_wdata(lb_wdata), .lb_rdata(lb_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  // Register contents the bus returns for a given address.
  function automatic logic [DW-1:0] bus_val(input logic [AW-1:0] ad);
    if (ad == 24'h000010) return 32'hDEADBEEF;
    return {8'h00, ad} + 32'h100;
  endfunction

  // Bus: data is valid exactly RL cycles after a read strobe, noise otherwise.
  logic [DW-1:0] sched [int];
  always @(negedge clk) if (lb_strobe && lb_rd) sched[cyc + RL] = bus_val(lb_addr);
  initial forever begin
    @(posedge clk); #1;
    if (sched.exists(cyc)) begin
      lb_rdata = sched[cyc];
      sched.delete(cyc);
    end else begin
      lb_rdata = $urandom;
    end
  end

  // Reference model: grant rule by last winner and its streak length,
  // expected bus cycle one cycle later, returns queued by due cycle.
  typedef struct { int due; int id; logic [DW-1:0] data; } ret_t;
  ret_t          pend[$];
  ret_t          p;
  int            m_last = 1, m_streak = BM, m_id = 0, win;
  logic          m_strobe = 0, m_rd = 0, m_arv, m_brv;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_ard = '0, m_brd = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", {a_gnt, b_gnt}, 0);
      chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      chk("rst_lb_ctl", {lb_strobe, lb_rd}, 0);
      chk("rst_lb_addr", lb_addr, 0);
      chk("rst_lb_wdata", lb_wdata, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      m_last = 1; m_streak = BM; m_strobe = 0; m_rd = 0; m_id = 0;
      m_addr = '0; m_wdata = '0; m_ard = '0; m_brd = '0;
      pend.delete();
    end else begin
      m_arv = 0; m_brv = 0;
      if (pend.size() != 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        if (p.id == 0) begin m_arv = 1; m_ard = p.data; end
        else begin m_brv = 1; m_brd = p.data; end
      end
      if (a_req && b_req) win = (m_streak < BM) ? m_last : 1 - m_last;
      else if (a_req) win = 0;
      else if (b_req) win = 1;
      else win = -1;
      chk("a_gnt", a_gnt, win == 0);
      chk("b_gnt", b_gnt, win == 1);
      chk("lb_strobe", lb_strobe, m_strobe);
      chk("lb_rd", lb_rd, m_rd);
      chk("lb_addr", lb_addr, m_addr);
      chk("lb_wdata", lb_wdata, m_wdata);
      chk("a_rvalid", a_rvalid, m_arv);
      chk("a_rdata", a_rdata, m_ard);
      chk("b_rvalid", b_rvalid, m_brv);
      chk("b_rdata", b_rdata, m_brd);
      if (m_strobe && m_rd) pend.push_back('{cyc + RL + 1, m_id, bus_val(m_addr)});
      if (win >= 0) begin
        if (win == m_last) m_streak = (m_streak < BM) ? m_streak + 1 : BM;
        else begin m_last = win; m_streak = 1; end
        m_strobe = 1; m_id = win;
        m_rd    = (win == 1) ? b_rd    : a_rd;
        m_addr  = (win == 1) ? b_addr  : a_addr;
        m_wdata = (win == 1) ? b_wdata : a_wdata;
      end else begin
        m_strobe = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_a(input logic r, input logic rd, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    a_req = r; a_rd = rd; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic r, input logic rd, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    b_req = r; b_rd = rd; b_addr = ad; b_wdata = wd;
  endtask

  task automatic idle();
    a_req = 0; b_req = 0;
  endtask

  task automatic do_reset();
    tick(); idle(); rst_n = 0;
    tick(); rst_n = 1;
  endtask

  string seq;
  logic  a_took, b_took;

  initial begin
    tick(); tick(); rst_n = 1;
    tick();

    // Single A read of the DEADBEEF register.
    tick(); set_a(1, 1, 24'h000010, 0);
    @(negedge clk); chk("t1_gnt", a_gnt, 1);
    for (int k = 1; k <= 7; k++) begin
      tick(); if (k == 1) idle();
      @(negedge clk);
      if (k == 1) begin
        chk("t1_strobe", lb_strobe, 1);
        chk("t1_addr", lb_addr, 24'h000010);
        chk("t1_rd", lb_rd, 1);
      end
      chk("t1_a_rvalid", a_rvalid, k == 5);
      chk("t1_b_rvalid", b_rvalid, 0);
      if (k == 5) chk("t1_a_rdata", a_rdata, 32'hDEADBEEF);
    end

    // Both masters request continuously from reset.
    do_reset();
    tick(); set_a(1, 0, 24'h100, 1); set_b(1, 0, 24'h200, 2);
    seq = "";
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      seq = {seq, a_gnt ? "A" : (b_gnt ? "B" : "-")};
      if (i > 0) chk("t2_strobe", lb_strobe, 1);
      tick();
      a_addr = 24'(32'h100 + i + 1); b_addr = 24'(32'h200 + i + 1);
    end
    idle();
    n_vec++;
    if (seq != "AAAABBBBA") begin
      n_bad++;
      $display("FAIL t2_grant_seq: actual %s required AAAABBBBA", seq);
    end
    repeat (6) tick();

    // Alternating reads A1, B2, A3.
    for (int k = 0; k <= 9; k++) begin
      tick();
      idle();
      if (k == 0) set_a(1, 1, 24'h1, 0);
      if (k == 1) set_b(1, 1, 24'h2, 0);
      if (k == 2) set_a(1, 1, 24'h3, 0);
      @(negedge clk);
      chk("t3_a_rvalid", a_rvalid, (k == 5) || (k == 7));
      chk("t3_b_rvalid", b_rvalid, k == 6);
      if (k == 5) chk("t3_a_rdata0", a_rdata, 32'h101);
      if (k == 6) chk("t3_b_rdata", b_rdata, 32'h102);
      if (k == 7) chk("t3_a_rdata1", a_rdata, 32'h103);
      if (k == 9) chk("t3_hold", {a_rdata, b_rdata}, {32'h103, 32'h102});
    end

    // Single A write.
    for (int k = 0; k <= 7; k++) begin
      tick();
      idle();
      if (k == 0) set_a(1, 0, 24'h0000AB, 32'h12345678);
      @(negedge clk);
      if (k == 1) chk("t4_bus", {lb_strobe, lb_rd, lb_addr, lb_wdata},
                      {1'b1, 1'b0, 24'h0000AB, 32'h12345678});
      if (k == 2) chk("t4_hold", {lb_strobe, lb_addr}, {1'b0, 24'h0000AB});
      chk("t4_rvalid", {a_rvalid, b_rvalid}, 0);
    end

    // Reset pulse with two reads in flight, then a clean read.
    for (int k = 0; k <= 16; k++) begin
      tick();
      idle();
      if (k == 0) set_a(1, 1, 24'h5, 0);
      if (k == 1) set_b(1, 1, 24'h6, 0);
      if (k == 3) begin rst_n = 0; set_a(1, 1, 24'h7, 0); end
      if (k == 4) rst_n = 1;
      if (k == 10) set_a(1, 1, 24'h7, 0);
      @(negedge clk);
      if (k == 3) chk("t5_rst_outs", {a_gnt, b_gnt, lb_strobe, a_rdata, b_rdata}, 0);
      if (k != 15) chk("t5_no_rvalid", {a_rvalid, b_rvalid}, 0);
      if (k == 15) chk("t5_new_read", {a_rvalid, a_rdata}, {1'b1, 32'h107});
    end

`ifdef LB_ARB_STATS_EN
    do_reset();
    for (int k = 0; k <= 7; k++) begin
      tick();
      idle(); stats_clr = 0;
      case (k)
        0: begin set_a(1, 0, 24'h10, 0); set_b(1, 0, 24'h20, 0); end
        1: begin set_a(1, 0, 24'h11, 0); set_b(1, 0, 24'h20, 0); end
        2: set_b(1, 0, 24'h20, 0);
        3: set_a(1, 0, 24'h12, 0);
        4: set_b(1, 0, 24'h21, 0);
        6: stats_clr = 1;
        default: ;
      endcase
      @(negedge clk);
      if (k == 5) chk("stats_counts", {a_grants, b_grants, conflicts}, {16'd3, 16'd2, 16'd2});
      if (k == 7) chk("stats_clr", {a_grants, b_grants, conflicts}, 0);
    end
`endif

    // Randomized traffic with occasional reset pulses.
    a_took = 0; b_took = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); a_took = a_gnt; b_took = b_gnt;
      tick();
      if (!a_req || a_took) set_a($urandom_range(0, 2) != 0, 1'($urandom), 24'($urandom), $urandom);
      if (!b_req || b_took) set_b($urandom_range(0, 2) != 0, 1'($urandom), 24'($urandom), $urandom);
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end
    idle(); rst_n = 1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
